// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg: constants and beat type shared by every pipeline stage     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package pipe_pkg;

   localparam int          PIPE_DATA_W = 32;
   localparam int          PIPE_SIDE_W = 8;
   localparam int unsigned PC_STEP     = 4;

   // sll $0,$0,0 encodes as all zeros
   localparam logic [PIPE_DATA_W-1:0] NOP_IR  = 32'h0000_0000;
   localparam logic [PIPE_DATA_W-1:0] PC_INIT = 32'h0000_0000;

   typedef struct packed {
      logic [PIPE_DATA_W-1:0] ir;
      logic [PIPE_DATA_W-1:0] pc;
      logic [PIPE_DATA_W-1:0] pc4;
      logic [PIPE_SIDE_W-1:0] side;
   } pipe_beat_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_stage_reg_if: upstream/downstream handshake and beat fields     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface pipe_stage_reg_if #(
   parameter int DATA_W = 32,
   parameter int SIDE_W = 8,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_ir;
   logic [DATA_W-1:0] in_pc;
   logic [SIDE_W-1:0] in_side;
   logic              stall;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_ir;
   logic [DATA_W-1:0] out_pc;
   logic [DATA_W-1:0] out_pc4;
   logic [SIDE_W-1:0] out_side;
   logic [CNT_W-1:0]  bubble_cnt;

   modport slave (
      input  in_valid, in_ir, in_pc, in_side, stall, flush, out_ready,
      output in_ready, out_valid, out_ir, out_pc, out_pc4, out_side, bubble_cnt
   );

   modport master (
      output in_valid, in_ir, in_pc, in_side, stall, flush, out_ready,
      input  in_ready, out_valid, out_ir, out_pc, out_pc4, out_side, bubble_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_entry.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_skid_entry: one valid bit plus beat register, load/clear/flush  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module pipe_skid_entry #(
   parameter int            W        = 104,
   parameter logic [W-1:0]  RST_DATA = '0
) (
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic         i_flush,
   input  wire logic         i_load,
   input  wire logic         i_clear,
   input  wire logic [W-1:0] i_data,
   output logic              o_valid,
   output logic [W-1:0]      o_data
);
   logic         r_valid;
   logic [W-1:0] r_data;

   // Clearing alone keeps the data; only reset and flush restore the idle beat
   always_ff @(posedge clk) begin
      if (!reset || i_flush) begin
         r_valid <= 1'b0;
         r_data  <= RST_DATA;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_stage_reg: stage register with skid buffer, stall, flush        |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module pipe_stage_reg #(
   parameter int                DATA_W  = 32,
   parameter int                SIDE_W  = 8,
   parameter logic [DATA_W-1:0] NOP_IR  = DATA_W'(pipe_pkg::NOP_IR),
   parameter logic [DATA_W-1:0] PC_INIT = DATA_W'(pipe_pkg::PC_INIT),
   parameter int                CNT_W   = 16
) (
   input  wire logic       clk,
   input  wire logic       reset,
   pipe_stage_reg_if.slave bus
);
   import pipe_pkg::*;

   localparam int                BEAT_W   = 3 * DATA_W + SIDE_W;
   localparam logic [BEAT_W-1:0] RST_BEAT =
      {NOP_IR, PC_INIT, PC_INIT + DATA_W'(PC_STEP), {SIDE_W{1'b0}}};

   logic              w_main_valid;
   logic              w_skid_valid;
   logic [BEAT_W-1:0] w_main_beat;
   logic [BEAT_W-1:0] w_skid_beat;
   logic [BEAT_W-1:0] w_in_beat;
   logic [BEAT_W-1:0] w_main_src;
   logic              w_accept;
   logic              w_drain;
   logic              w_main_load;
   logic              w_main_clear;
   logic              w_skid_load;
   logic              w_skid_clear;
   logic [CNT_W-1:0]  r_bubble_cnt;

   assign w_in_beat = {bus.in_ir, bus.in_pc, bus.in_pc + DATA_W'(PC_STEP), bus.in_side};
   assign w_accept  = bus.in_valid && !w_skid_valid;
   assign w_drain   = w_main_valid && bus.out_ready && !bus.stall;

   // Skid is only ever occupied behind a held main entry, so in_ready = !skid.valid
   always_comb begin
      w_main_load  = 1'b0;
      w_main_clear = 1'b0;
      w_main_src   = w_in_beat;
      w_skid_load  = 1'b0;
      w_skid_clear = 1'b0;
      if (!bus.flush) begin
         if (w_drain && w_skid_valid) begin
            w_main_load  = 1'b1;
            w_main_src   = w_skid_beat;
            w_skid_clear = 1'b1;
         end else if (w_drain || !w_main_valid) begin
            w_main_load  = w_accept;
            w_main_clear = !w_accept;
         end else if (w_accept) begin
            w_skid_load  = 1'b1;
         end
      end
   end

   pipe_skid_entry #(.W(BEAT_W), .RST_DATA(RST_BEAT)) u_main (
      .clk     (clk),
      .reset   (reset),
      .i_flush (bus.flush),
      .i_load  (w_main_load),
      .i_clear (w_main_clear),
      .i_data  (w_main_src),
      .o_valid (w_main_valid),
      .o_data  (w_main_beat)
   );

   pipe_skid_entry #(.W(BEAT_W), .RST_DATA(RST_BEAT)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .i_flush (bus.flush),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_data  (w_in_beat),
      .o_valid (w_skid_valid),
      .o_data  (w_skid_beat)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bubble_cnt <= '0;
      end else if (!w_main_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
         r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
   end

   assign bus.in_ready   = !w_skid_valid;
   assign bus.out_valid  = w_main_valid;
   assign {bus.out_ir, bus.out_pc, bus.out_pc4, bus.out_side} = w_main_beat;
   assign bus.bubble_cnt = r_bubble_cnt;
endmodule
`default_nettype wire
